// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared widths, constants and state type for the equalizer band mixer
package eq_pkg;

  localparam int N_BANDS = 8;
  localparam int IN_W    = 32;
  localparam int GAIN_W  = 16;
  localparam int OUT_W   = 16;
  localparam int SHIFT   = 27;

  localparam int PROD_W  = IN_W + GAIN_W;
  localparam int ACC_W   = IN_W + GAIN_W + $clog2(N_BANDS);
  localparam int BAND_W  = $clog2(N_BANDS);
  localparam int CNT_W   = BAND_W + 1;

  localparam logic [GAIN_W-1:0] GAIN_UNITY = 16'h1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } mix_state_e;

endpackage

// File: rtl/eq_round_sat.sv
// rtl/eq_round_sat.sv - round-half-up and clamp from accumulator width to output width
module eq_round_sat
  import eq_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] y_o,
  output logic                    sat_o
);

  localparam int RW = ACC_W + 1 - SHIFT;
  localparam logic signed [ACC_W:0]   ROUND = (ACC_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [RW-1:0]    R_MAX = RW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [RW-1:0]    R_MIN = RW'(-(2 ** (OUT_W - 1)));
  localparam logic signed [OUT_W-1:0] Y_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] Y_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W:0] biased;
  logic signed [RW-1:0]  r;

  // One guard bit keeps the rounding bias from wrapping at the accumulator extreme.
  always_comb begin
    biased = {acc_i[ACC_W-1], acc_i} + ROUND;
    r      = RW'(biased >>> SHIFT);
    sat_o  = 1'b0;
    y_o    = r[OUT_W-1:0];
    if (r > R_MAX) begin
      y_o   = Y_MAX;
      sat_o = 1'b1;
    end else if (r < R_MIN) begin
      y_o   = Y_MIN;
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/eq_band_mixer.sv
// rtl/eq_band_mixer.sv - per-band gain, time-multiplexed MAC and round/saturate to one audio sample
// Optional peak-magnitude tracker enabled by EQ_MIXER_PEAK_EN.
module eq_band_mixer
  import eq_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      in_valid,
  input  logic [N_BANDS*IN_W-1:0]   band_in,
  input  logic                      gain_wr,
  input  logic [2:0]                gain_addr,
  input  logic signed [GAIN_W-1:0]  gain_data,
  output logic                      busy,
  output logic                      out_valid,
  output logic signed [OUT_W-1:0]   y_out,
  output logic                      sat_flag,
`ifdef EQ_MIXER_PEAK_EN
  input  logic                      peak_clr,
  output logic [OUT_W-1:0]          peak_abs,
`endif
  output logic                      overrun
);

  mix_state_e               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [OUT_W-1:0]  y_q, y_d;
  logic                     sat_q, sat_d;
  logic                     vld_q, vld_d;
  logic                     overrun_q;
  logic                     capture;
  logic [N_BANDS-1:0]       wr_hit;
  logic [BAND_W-1:0]        idx;
  logic signed [OUT_W-1:0]  rs_y;
  logic                     rs_sat;

  logic signed [IN_W-1:0]   buf_q    [N_BANDS];
  logic signed [GAIN_W-1:0] shadow_q [N_BANDS];
  logic signed [GAIN_W-1:0] active_q [N_BANDS];

  eq_round_sat u_round_sat (
    .acc_i (acc_q),
    .y_o   (rs_y),
    .sat_o (rs_sat)
  );

  always_comb begin
    for (int i = 0; i < N_BANDS; i++) begin
      wr_hit[i] = gain_wr && (gain_addr == 3'(i));
    end
  end

  assign idx = cnt_q[BAND_W-1:0];

  // Products are registered, so MAC runs one extra drain cycle to fold in the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    y_d     = y_q;
    sat_d   = sat_q;
    vld_d   = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          state_d = ST_MAC;
          cnt_d   = '0;
          acc_d   = '0;
          prod_d  = '0;
        end
      end
      ST_MAC: begin
        acc_d = acc_q + ACC_W'(prod_q);
        if (cnt_q < CNT_W'(N_BANDS)) begin
          prod_d = PROD_W'(buf_q[idx]) * PROD_W'(active_q[idx]);
        end else begin
          prod_d = '0;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N_BANDS)) begin
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        y_d     = rs_y;
        sat_d   = rs_sat;
        vld_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!ena) begin
      state_d = ST_IDLE;
      capture = 1'b0;
      y_d     = '0;
      sat_d   = 1'b0;
      vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      prod_q    <= '0;
      y_q       <= '0;
      sat_q     <= 1'b0;
      vld_q     <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N_BANDS; i++) begin
        buf_q[i]    <= '0;
        shadow_q[i] <= GAIN_UNITY;
        active_q[i] <= GAIN_UNITY;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      prod_q    <= prod_d;
      y_q       <= y_d;
      sat_q     <= sat_d;
      vld_q     <= vld_d;
      overrun_q <= overrun_q | (in_valid && (state_q != ST_IDLE));
      for (int i = 0; i < N_BANDS; i++) begin
        if (wr_hit[i]) begin
          shadow_q[i] <= gain_data;
        end
        // A write landing on the capture edge bypasses the shadow so this sample sees it.
        if (capture) begin
          buf_q[i]    <= band_in[i*IN_W +: IN_W];
          active_q[i] <= wr_hit[i] ? gain_data : shadow_q[i];
        end
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = vld_q;
  assign y_out     = y_q;
  assign sat_flag  = sat_q;
  assign overrun   = overrun_q;

`ifdef EQ_MIXER_PEAK_EN
  logic [OUT_W-1:0] peak_q;
  logic [OUT_W-1:0] y_abs;

  always_comb begin
    y_abs = y_d;
    if (y_d[OUT_W-1]) begin
      y_abs = (y_d == {1'b1, {(OUT_W-1){1'b0}}}) ? {1'b0, {(OUT_W-1){1'b1}}} : OUT_W'(-y_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q <= '0;
    end else if (vld_d) begin
      peak_q <= (peak_clr || (y_abs > peak_q)) ? y_abs : peak_q;
    end else if (peak_clr) begin
      peak_q <= '0;
    end
  end

  assign peak_abs = peak_q;
`endif

endmodule

// File: tb/tb_eq_band_mixer.sv
// tb/tb_eq_band_mixer.sv - randomized self-checking bench for eq_band_mixer
module tb_eq_band_mixer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b0;
  logic         in_valid = 1'b0;
  logic [255:0] band_in = '0;
  logic         gain_wr = 1'b0;
  logic [2:0]   gain_addr = '0;
  logic [15:0]  gain_data = '0;
  logic         busy, out_valid, sat_flag, overrun;
  logic [15:0]  y_out;
`ifdef EQ_MIXER_PEAK_EN
  logic         peak_clr = 1'b0;
  logic [15:0]  peak_abs;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [15:0] m_gain [8];
  logic signed [31:0] bands  [8];

  eq_band_mixer dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .in_valid  (in_valid),
    .band_in   (band_in),
    .gain_wr   (gain_wr),
    .gain_addr (gain_addr),
    .gain_data (gain_data),
    .busy      (busy),
    .out_valid (out_valid),
    .y_out     (y_out),
    .sat_flag  (sat_flag),
`ifdef EQ_MIXER_PEAK_EN
    .peak_clr  (peak_clr),
    .peak_abs  (peak_abs),
`endif
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  function automatic void model(output logic [15:0] y, output logic s);
    longint acc, r;
    acc = 0;
    for (int i = 0; i < 8; i++) acc += longint'(bands[i]) * longint'(m_gain[i]);
    r = (acc + 64'sd67108864) >>> 27;
    s = 1'b0;
    if (r > 32767) begin
      y = 16'h7FFF; s = 1'b1;
    end else if (r < -32768) begin
      y = 16'h8000; s = 1'b1;
    end else begin
      y = 16'(r);
    end
  endfunction

  task automatic set_all(input logic [31:0] v);
    for (int i = 0; i < 8; i++) bands[i] = v;
  endtask

  task automatic write_gain(input int a, input logic [15:0] d);
    @(negedge clk);
    gain_wr = 1'b1; gain_addr = 3'(a); gain_data = d;
    m_gain[a] = d;
    @(negedge clk);
    gain_wr = 1'b0;
  endtask

  task automatic pulse_in();
    @(negedge clk);
    for (int i = 0; i < 8; i++) band_in[i*32 +: 32] = bands[i];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!out_valid && cyc < 40);
  endtask

  task automatic test_reset();
    logic [15:0] ey; logic es; int lat;
    rst = 1'b1; ena = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (y_out !== 16'h0)  begin n_fail++; $display("FAIL reset_y got=%h exp=0000", y_out); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    n_tests++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat got=%b exp=0", sat_flag); end
    rst = 1'b0;
    set_all(32'h0); bands[0] = 32'h0800_0000;
    model(ey, es);
    pulse_in(); wait_out(lat);
    n_tests++; if (out_valid !== 1'b1 || y_out !== 16'h1000) begin n_fail++; $display("FAIL default_gain got=%h v=%b exp=1000 model=%h", y_out, out_valid, ey); end
  endtask

  task automatic test_latency();
    logic [15:0] ey; logic es; int lat;
    for (int i = 1; i < 8; i++) write_gain(i, 16'h0000);
    set_all(32'h0800_0000);
    model(ey, es);
    pulse_in();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_capture got=%b exp=1", busy); end
    wait_out(lat);
    n_tests++; if (lat !== 10) begin n_fail++; $display("FAIL latency got=%0d exp=10", lat); end
    n_tests++; if (y_out !== 16'd4096 || y_out !== ey) begin n_fail++; $display("FAIL band0_only got=%h exp=%h", y_out, ey); end
    n_tests++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL band0_sat got=%b exp=0", sat_flag); end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL pulse_width valid=%b busy=%b exp=0/0", out_valid, busy); end
    n_tests++; if (y_out !== ey) begin n_fail++; $display("FAIL y_hold got=%h exp=%h", y_out, ey); end
  endtask

  task automatic test_saturation();
    int lat;
    for (int i = 1; i < 8; i++) write_gain(i, 16'h1000);
    set_all(32'h7FFF_FFFF);
    pulse_in(); wait_out(lat);
    n_tests++; if (y_out !== 16'h7FFF || sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_pos got=%h/%b exp=7fff/1", y_out, sat_flag); end
    set_all(32'h8000_0000);
    pulse_in(); wait_out(lat);
    n_tests++; if (y_out !== 16'h8000 || sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_neg got=%h/%b exp=8000/1", y_out, sat_flag); end
  endtask

  task automatic test_overrun();
    logic [15:0] ey; logic es; logic [15:0] got; int pulses;
    set_all(32'h0); bands[2] = 32'h0123_4567;
    model(ey, es);
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_pre got=%b exp=0", overrun); end
    pulse_in();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) band_in[i*32 +: 32] = 32'h0700_0000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    pulses = 0; got = '0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin pulses++; got = y_out; end
    end
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL overrun_pulses got=%0d exp=1", pulses); end
    n_tests++; if (got !== ey) begin n_fail++; $display("FAIL overrun_result got=%h exp=%h", got, ey); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    // in_valid presented during the OUT cycle is dropped as well
    pulse_in();
    repeat (9) @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b1 || y_out !== ey) begin n_fail++; $display("FAIL out_cycle_result got=%h v=%b exp=%h", y_out, out_valid, ey); end
    @(negedge clk);
    in_valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    n_tests++; if (pulses !== 0 || overrun !== 1'b1) begin n_fail++; $display("FAIL out_cycle_drop pulses=%0d overrun=%b exp=0/1", pulses, overrun); end
  endtask

  task automatic test_gain_in_flight();
    logic [15:0] ea, eb, ec; logic es; int lat;
    set_all(32'h0); bands[0] = 32'h0800_0000;
    model(ea, es);
    pulse_in();
    write_gain(0, 16'h2000);
    wait_out(lat);
    n_tests++; if (y_out !== ea || y_out !== 16'd4096) begin n_fail++; $display("FAIL inflight_a got=%h exp=%h", y_out, ea); end
    model(eb, es);
    pulse_in(); wait_out(lat);
    n_tests++; if (y_out !== eb || y_out !== 16'd8192) begin n_fail++; $display("FAIL inflight_b got=%h exp=%h", y_out, eb); end
    @(negedge clk);
    for (int i = 0; i < 8; i++) band_in[i*32 +: 32] = bands[i];
    in_valid = 1'b1; gain_wr = 1'b1; gain_addr = 3'd0; gain_data = 16'h0800;
    m_gain[0] = 16'h0800;
    model(ec, es);
    @(negedge clk);
    in_valid = 1'b0; gain_wr = 1'b0;
    wait_out(lat);
    n_tests++; if (y_out !== ec || lat !== 10) begin n_fail++; $display("FAIL capture_write got=%h lat=%0d exp=%h/10", y_out, lat, ec); end
  endtask

  task automatic test_ena_drop();
    logic [15:0] ey; logic es; int pulses, lat;
    set_all(32'h0100_0000);
    pulse_in();
    repeat (4) @(negedge clk);
    ena = 1'b0;
    write_gain(1, 16'h0800);
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL ena_no_out got=%0d exp=0", pulses); end
    n_tests++; if (y_out !== 16'h0 || busy !== 1'b0 || sat_flag !== 1'b0) begin n_fail++; $display("FAIL ena_idle y=%h busy=%b sat=%b exp=0/0/0", y_out, busy, sat_flag); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ena_overrun_kept got=%b exp=1", overrun); end
    @(negedge clk); ena = 1'b1;
    for (int i = 0; i < 8; i++) bands[i] = $signed($urandom) >>> 9;
    model(ey, es);
    pulse_in(); wait_out(lat);
    n_tests++; if (y_out !== ey || sat_flag !== es || lat !== 10) begin n_fail++; $display("FAIL ena_resume got=%h/%b lat=%0d exp=%h/%b", y_out, sat_flag, lat, ey, es); end
  endtask

  task automatic test_rst_mid();
    logic [15:0] ey; logic es; int lat;
    write_gain(0, 16'h3000);
    set_all(32'h0); bands[0] = 32'h0800_0000;
    pulse_in();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #2;
    n_tests++; if (busy !== 1'b0 || overrun !== 1'b0 || y_out !== 16'h0) begin n_fail++; $display("FAIL rst_mid busy=%b overrun=%b y=%h exp=0/0/0", busy, overrun, y_out); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m_gain[i] = 16'h1000;
    model(ey, es);
    pulse_in(); wait_out(lat);
    n_tests++; if (y_out !== ey || y_out !== 16'h1000) begin n_fail++; $display("FAIL rst_gains got=%h exp=%h", y_out, ey); end
  endtask

  task automatic test_random();
    logic [15:0] ey; logic es; int lat;
    for (int n = 0; n < 20; n++) begin
      write_gain($urandom_range(0, 7), 16'($urandom));
      write_gain($urandom_range(0, 7), 16'($urandom_range(0, 16'h2000)));
      for (int i = 0; i < 8; i++) bands[i] = $signed($urandom) >>> $urandom_range(0, 12);
      model(ey, es);
      pulse_in(); wait_out(lat);
      n_tests++;
      if (y_out !== ey || sat_flag !== es || lat !== 10) begin
        n_fail++;
        $display("FAIL random[%0d] got=%h/%b lat=%0d exp=%h/%b/10", n, y_out, sat_flag, lat, ey, es);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_gain[i] = 16'h1000;
    test_reset();
    test_latency();
    test_saturation();
    test_overrun();
    test_gain_in_flight();
    test_ena_drop();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
